// File: rtl/ifq_pkg.sv
// ifq_pkg: shared types and constants for the instruction fetch queue.
//   ifq_state_e  - fetch FSM state encoding (FETCH, WAIT, DROP)
//   IFQ_DEPTH    - default FIFO depth (power of two, >= 2)
//   IFQ_RESET_PC - default fetch PC after reset
//   IFQ_ENTRY_W  - FIFO entry width: {instruction, pc_4}
//   IFQ_PTR_W    - FIFO pointer width for the default depth
package ifq_pkg;

  typedef enum logic [1:0] {
    FETCH = 2'd0,  // may issue a request when a slot is free
    WAIT  = 2'd1,  // one request outstanding, its return is kept
    DROP  = 2'd2   // one request outstanding, its return is discarded
  } ifq_state_e;

  localparam int unsigned IFQ_DEPTH    = 4;
  localparam logic [31:0] IFQ_RESET_PC = 32'h0000_0000;
  localparam int unsigned IFQ_ENTRY_W  = 64;
  localparam int unsigned IFQ_PTR_W    = $clog2(IFQ_DEPTH);

endpackage

// File: rtl/ifq_fifo.sv
// ifq_fifo: synchronous show-ahead FIFO with flush.
//   clk_i, rst_i   - clock, synchronous active-high reset (clears storage too)
//   flush_i        - drop all entries (count = 0, read pointer = write pointer)
//   wr_en_i/wr_data_i - push one entry (ignored when full)
//   rd_en_i        - pop the head entry (ignored when empty)
//   rd_data_o      - head entry, valid whenever empty_o = 0
//   count_o        - number of valid entries, 0..DEPTH
//   empty_o/full_o - occupancy flags
module ifq_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 64
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     flush_i,
  input  logic                     wr_en_i,
  input  logic [WIDTH-1:0]         wr_data_i,
  input  logic                     rd_en_i,
  output logic [WIDTH-1:0]         rd_data_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     empty_o,
  output logic                     full_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_wr, do_rd;

  assign empty_o   = (count_q == '0);
  assign full_o    = (count_q == CNT_W'(DEPTH));
  assign count_o   = count_q;
  assign rd_data_o = mem_q[rd_ptr_q];

  assign do_wr = wr_en_i && !full_o && !flush_i;
  assign do_rd = rd_en_i && !empty_o && !flush_i;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      // Flush keeps the write pointer where it is and snaps the read side to it.
      rd_ptr_d = wr_ptr_q;
      count_d  = '0;
    end else begin
      if (do_wr) wr_ptr_d = wr_ptr_q + 1'b1;  // power-of-two depth: wraps naturally
      if (do_rd) rd_ptr_d = rd_ptr_q + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (do_wr) mem_q[wr_ptr_q] <= wr_data_i;
    end
  end

endmodule

// File: rtl/ifetch_queue.sv
// ifetch_queue: instruction fetch queue in front of dispatch.
//   clock, reset        - clock, synchronous active-high reset
//   Icache_addr         - fetch address (always the fetch PC)
//   Icache_rd_en        - read request, accepted by the cache in the same cycle
//   Icache_data/valid   - returned word for the single outstanding request
//   Dispatch_jmp/_addr  - redirect: flush queue, drop in-flight return, new PC
//   Dispatch_ren        - pop the head entry
//   ifetch_intruction   - head instruction (show-ahead)
//   ifetch_pc_4         - PC+4 of the head instruction
//   ifetch_empty        - no valid head entry
//
// Handshake: a request is issued when Icache_rd_en = 1 and is taken by the
// cache that same cycle; the cache answers it with exactly one Icache_valid
// pulse some cycles later, and Icache_valid at any other time is ignored.
// Dispatch pops with Dispatch_ren, which only takes effect when
// ifetch_empty = 0 and no redirect is present in the same cycle.
// The FSM state is held in state_q.
module ifetch_queue
  import ifq_pkg::*;
#(
  parameter int unsigned DEPTH    = IFQ_DEPTH,
  parameter logic [31:0] RESET_PC = IFQ_RESET_PC
) (
  input  logic        clock,
  input  logic        reset,
  output logic [31:0] Icache_addr,
  output logic        Icache_rd_en,
  input  logic [31:0] Icache_data,
  input  logic        Icache_valid,
  input  logic        Dispatch_jmp,
  input  logic [31:0] Dispatch_jmp_addr,
  input  logic        Dispatch_ren,
  output logic [31:0] ifetch_intruction,
  output logic [31:0] ifetch_pc_4,
  output logic        ifetch_empty
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  ifq_state_e state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pc_plus4;
  logic        req;

  logic                   fifo_flush;
  logic                   fifo_wr;
  logic                   fifo_rd;
  logic [IFQ_ENTRY_W-1:0] fifo_wdata;
  logic [IFQ_ENTRY_W-1:0] fifo_rdata;
  logic [CNT_W-1:0]       fifo_count;
  logic                   fifo_empty;
  logic                   fifo_full;

  assign pc_plus4    = pc_q + 32'd4;
  assign Icache_addr = pc_q;

  // A request reserves a FIFO slot, so the WAIT-state write can never overflow.
  assign req          = (state_q == FETCH) && (fifo_count < CNT_W'(DEPTH)) && !reset;
  assign Icache_rd_en = req;

  assign fifo_wdata = {Icache_data, pc_plus4};

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    fifo_wr    = 1'b0;
    fifo_flush = 1'b0;
    fifo_rd    = Dispatch_ren && !Dispatch_jmp;

    if (Dispatch_jmp) begin
      fifo_flush = 1'b1;
      pc_d       = Dispatch_jmp_addr;
      case (state_q)
        FETCH:   state_d = req ? DROP : FETCH;          // request just issued is stale
        WAIT,
        DROP:    state_d = Icache_valid ? FETCH : DROP; // same-cycle return is discarded
        default: state_d = FETCH;
      endcase
    end else begin
      case (state_q)
        FETCH: if (req) state_d = WAIT;
        WAIT: if (Icache_valid) begin
          fifo_wr = !fifo_full;
          pc_d    = pc_plus4;
          state_d = FETCH;
        end
        DROP: if (Icache_valid) state_d = FETCH;
        default: state_d = FETCH;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  ifq_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (IFQ_ENTRY_W)
  ) u_fifo (
    .clk_i     (clock),
    .rst_i     (reset),
    .flush_i   (fifo_flush),
    .wr_en_i   (fifo_wr),
    .wr_data_i (fifo_wdata),
    .rd_en_i   (fifo_rd),
    .rd_data_o (fifo_rdata),
    .count_o   (fifo_count),
    .empty_o   (fifo_empty),
    .full_o    (fifo_full)
  );

  assign ifetch_intruction = fifo_rdata[63:32];
  assign ifetch_pc_4       = fifo_rdata[31:0];
  assign ifetch_empty      = fifo_empty;

endmodule

// File: tb/tb_ifetch_queue.sv
module tb_ifetch_queue;
  import ifq_pkg::*;

  // clock / reset
  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] Icache_addr;
  logic        Icache_rd_en;
  logic [31:0] Icache_data = '0;
  logic        Icache_valid = 1'b0;
  logic        Dispatch_jmp = 1'b0;
  logic [31:0] Dispatch_jmp_addr = '0;
  logic        Dispatch_ren = 1'b0;
  logic [31:0] ifetch_intruction;
  logic [31:0] ifetch_pc_4;
  logic        ifetch_empty;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  ifetch_queue #(.DEPTH(4), .RESET_PC(32'h0)) dut (
    .clock             (clock),
    .reset             (reset),
    .Icache_addr       (Icache_addr),
    .Icache_rd_en      (Icache_rd_en),
    .Icache_data       (Icache_data),
    .Icache_valid      (Icache_valid),
    .Dispatch_jmp      (Dispatch_jmp),
    .Dispatch_jmp_addr (Dispatch_jmp_addr),
    .Dispatch_ren      (Dispatch_ren),
    .ifetch_intruction (ifetch_intruction),
    .ifetch_pc_4       (ifetch_pc_4),
    .ifetch_empty      (ifetch_empty)
  );

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  // scoreboard-style check
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic [31:0] pc);
    return 32'hA500_0000 ^ pc;
  endfunction

  // driver tasks
  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  // Expect a request at pc, answer it one cycle later (k = 1), optional pop with the write.
  task automatic fetch_one(input logic [31:0] pc, input logic pop);
    #1;
    check("req_en", 64'(Icache_rd_en), 64'(1'b1));
    check("req_addr", 64'(Icache_addr), 64'(pc));
    tick();
    check("wait_rd_en", 64'(Icache_rd_en), 64'(1'b0));
    Icache_valid = 1'b1;
    Icache_data  = mk(pc);
    Dispatch_ren = pop;
    tick();
    Icache_valid = 1'b0;
    Icache_data  = '0;
    Dispatch_ren = 1'b0;
  endtask

  initial begin
    // ---- reset state
    reset = 1'b1;
    tick();
    tick();
    check("rst_rd_en", 64'(Icache_rd_en), 64'(1'b0));
    check("rst_empty", 64'(ifetch_empty), 64'(1'b1));
    check("rst_instr", 64'(ifetch_intruction), 64'h0);
    check("rst_pc4", 64'(ifetch_pc_4), 64'h0);
    check("rst_addr", 64'(Icache_addr), 64'h0);
    reset = 1'b0;

    // ---- k = 1 fill, first entry visible two cycles after the request
    fetch_one(32'h0, 1'b0);
    #1;
    check("first_empty", 64'(ifetch_empty), 64'(1'b0));
    check("first_instr", 64'(ifetch_intruction), 64'(mk(32'h0)));
    check("first_pc4", 64'(ifetch_pc_4), 64'h4);
    fetch_one(32'h4, 1'b0);
    fetch_one(32'h8, 1'b0);
    fetch_one(32'hC, 1'b0);

    // ---- full: no more requests
    #1;
    check("full_rd_en", 64'(Icache_rd_en), 64'(1'b0));
    check("full_addr", 64'(Icache_addr), 64'h10);
    tick();
    tick();
    check("full_rd_en2", 64'(Icache_rd_en), 64'(1'b0));
    check("full_count", 64'(dut.u_fifo.count_q), 64'd4);
    check("full_head", 64'(ifetch_intruction), 64'(mk(32'h0)));

    // ---- one pop -> exactly one request at 0x10
    Dispatch_ren = 1'b1;
    tick();
    Dispatch_ren = 1'b0;
    #1;
    check("pop1_head", 64'(ifetch_intruction), 64'(mk(32'h4)));
    check("pop1_pc4", 64'(ifetch_pc_4), 64'h8);
    fetch_one(32'h10, 1'b0);
    #1;
    check("refull_rd_en", 64'(Icache_rd_en), 64'(1'b0));

    // ---- pop 0x4, then pop 0x8 while request 0x14 issues
    Dispatch_ren = 1'b1;
    tick();
    #1;
    check("pop2_head", 64'(ifetch_intruction), 64'(mk(32'h8)));
    check("req14_en", 64'(Icache_rd_en), 64'(1'b1));
    check("req14_addr", 64'(Icache_addr), 64'h14);
    tick();
    Dispatch_ren = 1'b0;
    #1;
    check("cnt2", 64'(dut.u_fifo.count_q), 64'd2);
    check("pop3_head", 64'(ifetch_intruction), 64'(mk(32'hC)));
    check("wait14_rd_en", 64'(Icache_rd_en), 64'(1'b0));
    // write + pop at count = 2
    Icache_valid = 1'b1;
    Icache_data  = mk(32'h14);
    Dispatch_ren = 1'b1;
    tick();
    Icache_valid = 1'b0;
    Dispatch_ren = 1'b0;
    #1;
    check("wrpop_cnt", 64'(dut.u_fifo.count_q), 64'd2);
    check("wrpop_head", 64'(ifetch_intruction), 64'(mk(32'h10)));
    check("wrpop_pc4", 64'(ifetch_pc_4), 64'h14);

    fetch_one(32'h18, 1'b0);
    fetch_one(32'h1C, 1'b0);

    // ---- drain across pointer wrap: 0x10, 0x14, 0x18, 0x1C
    #1;
    check("drain_full", 64'(dut.u_fifo.count_q), 64'd4);
    Dispatch_ren = 1'b1;
    check("drain0", 64'(ifetch_intruction), 64'(mk(32'h10)));
    tick();
    check("drain1", 64'(ifetch_intruction), 64'(mk(32'h14)));
    check("drain1_pc4", 64'(ifetch_pc_4), 64'h18);
    check("req20_addr", 64'(Icache_addr), 64'h20);
    check("req20_en", 64'(Icache_rd_en), 64'(1'b1));
    tick();
    check("drain2", 64'(ifetch_intruction), 64'(mk(32'h18)));
    tick();
    check("drain3", 64'(ifetch_intruction), 64'(mk(32'h1C)));
    check("drain3_pc4", 64'(ifetch_pc_4), 64'h20);
    tick();
    check("drained_empty", 64'(ifetch_empty), 64'(1'b1));
    // pop on empty is ignored
    tick();
    Dispatch_ren = 1'b0;
    #1;
    check("underflow_empty", 64'(ifetch_empty), 64'(1'b1));
    check("underflow_cnt", 64'(dut.u_fifo.count_q), 64'd0);
    check("still_wait", 64'(dut.state_q), 64'(WAIT));

    // ---- redirect in WAIT, return arrives one cycle later and is dropped
    Dispatch_jmp      = 1'b1;
    Dispatch_jmp_addr = 32'h100;
    tick();
    Dispatch_jmp = 1'b0;
    #1;
    check("jmp_state", 64'(dut.state_q), 64'(DROP));
    check("jmp_rd_en", 64'(Icache_rd_en), 64'(1'b0));
    check("jmp_addr", 64'(Icache_addr), 64'h100);
    Icache_valid = 1'b1;
    Icache_data  = 32'hDEAD_BEEF;
    tick();
    Icache_valid = 1'b0;
    #1;
    check("drop_empty", 64'(ifetch_empty), 64'(1'b1));
    check("drop_state", 64'(dut.state_q), 64'(FETCH));
    fetch_one(32'h100, 1'b0);
    #1;
    check("tgt_instr", 64'(ifetch_intruction), 64'(mk(32'h100)));
    check("tgt_pc4", 64'(ifetch_pc_4), 64'h104);

    // ---- redirect together with return in WAIT (pop also ignored)
    check("req104_addr", 64'(Icache_addr), 64'h104);
    tick();
    Icache_valid      = 1'b1;
    Icache_data       = mk(32'h104);
    Dispatch_jmp      = 1'b1;
    Dispatch_jmp_addr = 32'h200;
    Dispatch_ren      = 1'b1;
    tick();
    Icache_valid = 1'b0;
    Dispatch_jmp = 1'b0;
    Dispatch_ren = 1'b0;
    #1;
    check("jv_state", 64'(dut.state_q), 64'(FETCH));
    check("jv_addr", 64'(Icache_addr), 64'h200);
    check("jv_rd_en", 64'(Icache_rd_en), 64'(1'b1));
    check("jv_empty", 64'(ifetch_empty), 64'(1'b1));

    // ---- redirect in FETCH while a request is issued
    Dispatch_jmp      = 1'b1;
    Dispatch_jmp_addr = 32'h300;
    tick();
    Dispatch_jmp = 1'b0;
    #1;
    check("jf_state", 64'(dut.state_q), 64'(DROP));
    check("jf_addr", 64'(Icache_addr), 64'h300);
    Icache_valid = 1'b1;
    Icache_data  = 32'h1234_5678;
    tick();
    Icache_valid = 1'b0;
    #1;
    check("jf_back", 64'(dut.state_q), 64'(FETCH));
    check("jf_empty", 64'(ifetch_empty), 64'(1'b1));

    // ---- reset in WAIT with a pending return
    fetch_one(32'h300, 1'b0);
    #1;
    check("pre_rst_pc4", 64'(ifetch_pc_4), 64'h304);
    check("pre_rst_addr", 64'(Icache_addr), 64'h304);
    tick();
    reset = 1'b1;
    tick();
    check("mid_rst_rd_en", 64'(Icache_rd_en), 64'(1'b0));
    tick();
    check("post_rst_empty", 64'(ifetch_empty), 64'(1'b1));
    check("post_rst_instr", 64'(ifetch_intruction), 64'h0);
    reset        = 1'b0;
    Icache_valid = 1'b1;
    Icache_data  = 32'h0BAD_0BAD;
    #1;
    check("stale_state", 64'(dut.state_q), 64'(FETCH));
    check("stale_addr", 64'(Icache_addr), 64'(IFQ_RESET_PC));
    check("restart_en", 64'(Icache_rd_en), 64'(1'b1));
    tick();
    Icache_valid = 1'b0;
    #1;
    check("stale_ignored", 64'(ifetch_empty), 64'(1'b1));
    check("restart_wait", 64'(dut.state_q), 64'(WAIT));
    Icache_valid = 1'b1;
    Icache_data  = mk(32'h0);
    tick();
    Icache_valid = 1'b0;
    #1;
    check("restart_empty", 64'(ifetch_empty), 64'(1'b0));
    check("restart_instr", 64'(ifetch_intruction), 64'(mk(32'h0)));
    check("restart_pc4", 64'(ifetch_pc_4), 64'h4);

    // final report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
